// File: rtl/pool_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pool_sched                                               |
// | Description : Sequences a 2x2 max-pool job over NUM_CH channels of an  |
// |               IMG_W x IMG_H signed 8-bit feature map. Streams source   |
// |               pixels to an external pool datapath, one channel at a    |
// |               time, and writes each pooled result to the result        |
// |               memory.                                                  |
// | Options     : POOL_SCHED_TIMEOUT_EN - bounded DRAIN wait with sticky   |
// |               err flag. When undefined, DRAIN waits indefinitely and   |
// |               err is tied low.                                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module pool_sched #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int NUM_CH    = 4,
  parameter int DRAIN_MAX = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       rd_en,
  output logic [$clog2(NUM_CH*IMG_W*IMG_H)-1:0]      rd_addr,
  input  logic signed [7:0]                          rd_data,
  output logic                                       mp_clr_n,
  output logic                                       mp_in_valid,
  output logic signed [7:0]                          mp_in_data,
  input  logic                                       mp_out_valid,
  input  logic signed [7:0]                          mp_out_data,
  output logic                                       wr_en,
  output logic [$clog2(NUM_CH*IMG_W*IMG_H/4)-1:0]    wr_addr,
  output logic signed [7:0]                          wr_data,
  output logic                                       err
);

  // Geometry of one channel and derived counter/address widths
  localparam int c_PIX_PER_CH = IMG_W * IMG_H;
  localparam int c_OUT_PER_CH = (IMG_W / 2) * (IMG_H / 2);
  localparam int c_RD_AW      = $clog2(NUM_CH * IMG_W * IMG_H);
  localparam int c_WR_AW      = $clog2(NUM_CH * IMG_W * IMG_H / 4);
  localparam int c_PIX_W      = $clog2(c_PIX_PER_CH + 1);
  localparam int c_OC_W       = $clog2(c_OUT_PER_CH + 1);
  localparam int c_CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_CH_W-1:0]   r_ch;
  logic [c_PIX_W-1:0]  r_pix;
  logic [c_OC_W-1:0]   r_out_cnt;
  logic                r_rd_en_d;
  logic                r_clr_rel;

  logic w_start_job;
  logic w_count;
  logic w_out_done;
  logic w_last_pix;
  logic w_last_ch;
  logic w_timeout;

  // A job starts only when start is seen in IDLE; start is ignored elsewhere
  assign w_start_job = (r_state == ST_IDLE) && start;

  // A result is accepted only while pixels are flowing and the channel
  // still has room; surplus pulses are dropped without counting
  assign w_count = mp_out_valid
                 && ((r_state == ST_FEED) || (r_state == ST_DRAIN))
                 && (r_out_cnt < c_OC_W'(c_OUT_PER_CH));

  // Channel complete: either already full, or the final result lands now
  assign w_out_done = (r_out_cnt == c_OC_W'(c_OUT_PER_CH))
                    || (w_count && (r_out_cnt == c_OC_W'(c_OUT_PER_CH - 1)));

  assign w_last_pix = (r_pix == c_PIX_W'(c_PIX_PER_CH - 1));
  assign w_last_ch  = (r_ch == c_CH_W'(NUM_CH - 1));

`ifdef POOL_SCHED_TIMEOUT_EN
  localparam int c_DC_W = $clog2(DRAIN_MAX + 1);

  logic [c_DC_W-1:0] r_drain_cnt;
  logic              r_err;

  // DRAIN_MAX-th consecutive DRAIN cycle without completion gives up
  assign w_timeout = (r_drain_cnt == c_DC_W'(DRAIN_MAX - 1));

  // Cycles spent in the current DRAIN visit; restarts on every visit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_drain_cnt <= r_drain_cnt + c_DC_W'(1);
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Sticky timeout flag: set on give-up, cleared only by a new job or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_job) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_DRAIN) && !w_out_done && w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_drain_max;

  // Without the timeout option DRAIN never gives up
  assign w_timeout          = 1'b0;
  assign w_unused_drain_max = (DRAIN_MAX == 0);
  assign err                = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_CLR;
      ST_CLR:   w_next_state = ST_FEED;
      ST_FEED:  if (w_last_pix) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_out_done || w_timeout) w_next_state = ST_NEXT;
      ST_NEXT:  w_next_state = w_last_ch ? ST_FIN : ST_CLR;
      ST_FIN:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Channel index: zeroed at job start, advanced between channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch <= '0;
    end else if (w_start_job) begin
      r_ch <= '0;
    end else if ((r_state == ST_NEXT) && !w_last_ch) begin
      r_ch <= r_ch + c_CH_W'(1);
    end
  end

  // Raster pixel index within the current channel, one step per FEED cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
    end else if (r_state == ST_CLR) begin
      r_pix <= '0;
    end else if (r_state == ST_FEED) begin
      r_pix <= r_pix + c_PIX_W'(1);
    end
  end

  // Accepted-result count within the current channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else if (r_state == ST_CLR) begin
      r_out_cnt <= '0;
    end else if (w_count) begin
      r_out_cnt <= r_out_cnt + c_OC_W'(1);
    end
  end

  // Align the pixel valid with the source memory's one-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en_d <= 1'b0;
    end else begin
      r_rd_en_d <= (r_state == ST_FEED);
    end
  end

  // Keeps the datapath clear asserted until the first clock after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_rel <= 1'b0;
    end else begin
      r_clr_rel <= 1'b1;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);
  assign rd_en       = (r_state == ST_FEED);
  assign rd_addr     = c_RD_AW'(r_ch) * c_RD_AW'(c_PIX_PER_CH) + c_RD_AW'(r_pix);
  assign mp_clr_n    = r_clr_rel && (r_state != ST_CLR);
  assign mp_in_valid = r_rd_en_d;
  // Source data is forwarded without a register; held at zero when idle
  assign mp_in_data  = r_rd_en_d ? rd_data : 8'sd0;
  assign wr_en       = w_count;
  assign wr_addr     = c_WR_AW'(r_ch) * c_WR_AW'(c_OUT_PER_CH) + c_WR_AW'(r_out_cnt);
  assign wr_data     = w_count ? mp_out_data : 8'sd0;

endmodule
`default_nettype wire

// File: tb/tb_pool_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_pool_sched                                            |
// | Description : Self-checking bench for pool_sched with a source memory, |
// |               a behavioural 2x2 max-pool datapath stub and a           |
// |               scoreboard of expected result writes.                    |
// | Options     : POOL_SCHED_TIMEOUT_EN enables the drain-timeout scenario |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_pool_sched;

  localparam int W   = 28;
  localparam int H   = 28;
  localparam int NCH = 4;
  localparam int PIX = W * H;
  localparam int OPC = (W / 2) * (H / 2);

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           start;
  logic                           busy, done, rd_en;
  logic [$clog2(NCH*PIX)-1:0]     rd_addr;
  logic signed [7:0]              rd_data = 8'sd0;
  logic                           mp_clr_n, mp_in_valid;
  logic signed [7:0]              mp_in_data;
  logic                           mp_out_valid = 1'b0;
  logic signed [7:0]              mp_out_data = 8'sd0;
  logic                           wr_en;
  logic [$clog2(NCH*PIX/4)-1:0]   wr_addr;
  logic signed [7:0]              wr_data;
  logic                           err;

  pool_sched #(.IMG_W(W), .IMG_H(H), .NUM_CH(NCH), .DRAIN_MAX(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .mp_clr_n(mp_clr_n), .mp_in_valid(mp_in_valid), .mp_in_data(mp_in_data),
    .mp_out_valid(mp_out_valid), .mp_out_data(mp_out_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;

  logic signed [7:0] mem [0:NCH*PIX-1];
  logic signed [7:0] pbuf [0:PIX-1];
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;
  int  done_cnt = 0;
  int  wr_cnt   = 0;
  int  mode = 0;         // 0: real pooling stub, 1: burst of OPC+1 results
  int  stub_limit = OPC; // results emitted per channel in pooling mode
  int  s_cnt = 0;
  int  s_res = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                             input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Source feature map with one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Pool datapath stub: buffers a channel and emits each 2x2 max when the
  // window's bottom-right pixel arrives
  always @(posedge clk) begin
    if (!mp_clr_n) begin
      s_cnt = 0;
      s_res = 0;
      mp_out_valid <= 1'b0;
      mp_out_data  <= 8'sd0;
    end else begin
      mp_out_valid <= 1'b0;
      if (mode == 1) begin
        if (s_res < OPC + 1) begin
          mp_out_valid <= 1'b1;
          mp_out_data  <= 8'(s_res);
          s_res++;
        end
      end else if (mp_in_valid && s_cnt < PIX) begin
        pbuf[s_cnt] = mp_in_data;
        if (((s_cnt / W) % 2 == 1) && ((s_cnt % W) % 2 == 1) && s_res < stub_limit) begin
          mp_out_valid <= 1'b1;
          mp_out_data  <= smax(smax(pbuf[s_cnt-W-1], pbuf[s_cnt-W]),
                               smax(pbuf[s_cnt-1], pbuf[s_cnt]));
          s_res++;
        end
        s_cnt++;
      end
    end
  end

  // Scoreboard: every write must match the next expected result in order
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
  end

  // 0: ramp, 1: random, 2: random with channel 1 all -128 except (1,1)=127
  task automatic fill(input int kind);
    for (int a = 0; a < NCH * PIX; a++) begin
      if (kind == 0) mem[a] = 8'((a % PIX) + 3 * (a / PIX));
      else           mem[a] = 8'($urandom);
    end
    if (kind == 2) begin
      for (int p = 0; p < PIX; p++) mem[PIX + p] = -8'sd128;
      mem[PIX + 1 * W + 1] = 8'sd127;
    end
  endtask

  task automatic build_expect(input int m, input int limit);
    wr_t e;
    int  mx, v;
    exp_q.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < OPC; k++) begin
        e.addr = ch * OPC + k;
        if (m == 1) begin
          e.data = (k > 127) ? k - 256 : k;
          exp_q.push_back(e);
        end else if (k < limit) begin
          mx = -1000;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = mem[ch * PIX + (2 * (k / (W / 2)) + dr) * W + 2 * (k % (W / 2)) + dc];
              if (v > mx) mx = v;
            end
          e.data = mx;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_rd_en"},    rd_en, 0);
    check({tag, "_in_valid"}, mp_in_valid, 0);
    check({tag, "_wr_en"},    wr_en, 0);
    check({tag, "_err"},      err, 0);
    check({tag, "_clr_n"},    mp_clr_n, 0);
    check({tag, "_rd_addr"},  rd_addr, 0);
    check({tag, "_wr_addr"},  wr_addr, 0);
    check({tag, "_wr_data"},  wr_data, 0);
    check({tag, "_in_data"},  mp_in_data, 0);
  endtask

  // Runs one full job and checks writes, done, err and busy duration.
  // exp_busy = NCH*(CLR + PIX + DRAIN cycles + NEXT) + FIN
  task automatic run_job(input string tag, input int kind, input int m,
                         input int limit, input int exp_err,
                         input int exp_busy, input int glitch_at);
    int d0, w0, nb, exp_wr, err_at_done;
    bit seen;
    fill(kind);
    mode = m;
    stub_limit = limit;
    build_expect(m, limit);
    exp_wr = exp_q.size();
    d0 = done_cnt;
    w0 = wr_cnt;
    nb = 0;
    seen = 1'b0;
    err_at_done = -1;
    pulse_start();
    for (int i = 0; i < 20000 && !seen; i++) begin
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        err_at_done = err;
      end
      if (!seen) begin
        @(negedge clk);
        if (glitch_at > 0 && i == glitch_at)     start = 1'b1;
        if (glitch_at > 0 && i == glitch_at + 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_err"}, err_at_done, exp_err);
    @(negedge clk);
    #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_writes"}, wr_cnt - w0, exp_wr);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_busy_cycles"}, nb, exp_busy);
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    #1;
    check("clr_n_held", mp_clr_n, 0);
    @(posedge clk);
    #1;
    check("clr_n_released", mp_clr_n, 1);

    run_job("ramp",   0, 0, OPC, 0, NCH * (1 + PIX + 2 + 1) + 1, 0);
    run_job("spike",  2, 0, OPC, 0, NCH * (1 + PIX + 2 + 1) + 1, 0);
    run_job("rand",   1, 0, OPC, 0, NCH * (1 + PIX + 2 + 1) + 1, 0);
    run_job("glitch", 1, 0, OPC, 0, NCH * (1 + PIX + 2 + 1) + 1, 900);
    run_job("burst",  1, 1, OPC, 0, NCH * (1 + PIX + 1 + 1) + 1, 0);

    // Reset in the middle of channel 2 feeding
    fill(1);
    mode = 0;
    stub_limit = OPC;
    build_expect(0, OPC);
    d0 = done_cnt;
    pulse_start();
    repeat (1700) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_clr_n_held", mp_clr_n, 0);
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);

    run_job("after_rst", 1, 0, OPC, 0, NCH * (1 + PIX + 2 + 1) + 1, 0);

`ifdef POOL_SCHED_TIMEOUT_EN
    run_job("timeout", 1, 0, 100, 1, NCH * (1 + PIX + 64 + 1) + 1, 0);
    repeat (4) @(negedge clk);
    check("timeout_err_sticky", err, 1);
    run_job("post_timeout", 1, 0, OPC, 0, NCH * (1 + PIX + 2 + 1) + 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool_sched.md
POOL_SCHED -- requirements
Module: pool_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 28, feature-map width in pixels (even).
REQ-002 SHALL have parameter IMG_H, default 28, feature-map height in pixels (even).
REQ-003 SHALL have parameter NUM_CH, default 4, number of channels pooled per job.
REQ-004 SHALL have parameter DRAIN_MAX, default 64, drain-timeout limit in cycles.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at job end.
REQ-010 SHALL have port rd_en  output  1  source feature-map read strobe.
REQ-011 SHALL have port rd_addr  output  clog2(NUM_CH*IMG_W*IMG_H)  source address = ch*IMG_W*IMG_H + pix.
REQ-012 SHALL have port rd_data  input  8 signed  source data, valid one cycle after rd_en.
REQ-013 SHALL have port mp_clr_n  output  1  active-low clear to the pool datapath.
REQ-014 SHALL have port mp_in_valid  output  1  pixel valid to pool datapath.
REQ-015 SHALL have port mp_in_data  output  8 signed  pixel to pool datapath.
REQ-016 SHALL have port mp_out_valid  input  1  pooled result valid.
REQ-017 SHALL have port mp_out_data  input  8 signed  pooled result.
REQ-018 SHALL have port wr_en  output  1  result write strobe.
REQ-019 SHALL have port wr_addr  output  clog2(NUM_CH*IMG_W*IMG_H/4)  result address = ch*(IMG_W/2)*(IMG_H/2) + out_cnt.
REQ-020 SHALL have port wr_data  output  8 signed  result data.
REQ-021 SHALL have port err  output  1  sticky drain-timeout flag.

Function
REQ-022 SHALL implement FSM states IDLE, CLR, FEED, DRAIN, NEXT, FIN.
REQ-023 SHALL go IDLE->CLR on the clock edge where start=1 in IDLE; clear ch to 0 and err to 0 there.
REQ-024 SHALL drive mp_clr_n=0 for exactly the one cycle in CLR, 1 otherwise; zero pix and out_cnt in CLR; CLR->FEED.
REQ-025 SHALL in FEED assert rd_en every cycle, pix 0..IMG_W*IMG_H-1 raster order, one per cycle; FEED->DRAIN after pix = IMG_W*IMG_H-1.
REQ-026 SHALL drive mp_in_valid = rd_en delayed one cycle and mp_in_data = rd_data (combinational pass, no extra stage); no gaps within a channel.
REQ-027 SHALL count mp_out_valid pulses in FEED/DRAIN as out_cnt; each counted pulse produces wr_en=1, wr_data=mp_out_data, wr_addr per REQ-019 in the same cycle.
REQ-028 SHALL ignore (no write, no count) mp_out_valid once out_cnt = (IMG_W/2)*(IMG_H/2), and in IDLE, CLR, NEXT, FIN.
REQ-029 SHALL go DRAIN->NEXT when out_cnt reaches (IMG_W/2)*(IMG_H/2), including a last pulse arriving in the same cycle.
REQ-030 SHALL in NEXT go to FIN if ch = NUM_CH-1, else increment ch and go to CLR.
REQ-031 SHALL in FIN assert done for one cycle and return to IDLE; busy low from the following cycle.
REQ-032 SHALL ignore start while busy=1; start held high in IDLE after FIN begins a new job.
REQ-033 SHALL keep rd_en, mp_in_valid, wr_en at 0 outside the states named above.

Reset
REQ-034 SHALL on rst=1 immediately force state=IDLE, ch=pix=out_cnt=0, busy=done=rd_en=mp_in_valid=wr_en=err=0, mp_clr_n=0, rd_addr=wr_addr=0, wr_data=mp_in_data=0.
REQ-035 SHALL hold mp_clr_n=0 while rst=1 and release to 1 on the first clock after rst deasserts.
REQ-036 SHALL abandon any job in progress on rst mid-operation without emitting done.

Configuration
REQ-037 SHALL, with POOL_SCHED_TIMEOUT_EN defined, count cycles in DRAIN; at DRAIN_MAX cycles without completion set err=1 (sticky until next start or rst) and go to NEXT.
REQ-038 SHALL, without POOL_SCHED_TIMEOUT_EN, wait in DRAIN indefinitely and tie err to 0.

Verification
REQ-039 SHALL cover: reset, start pulse, NUM_CH=4, 28x28 ramp maps -> 784 writes, addresses 0..783 in order, done once, err=0.
REQ-040 SHALL cover: one channel all -128 except pixel (1,1)=127 -> wr_data at wr_addr ch*196+0 = 127, others -128.
REQ-041 SHALL cover: start asserted during FEED of ch 1 -> ignored, exactly one done, 784 writes total.
REQ-042 SHALL cover: rst pulsed mid-FEED of ch 2 -> all outputs 0 asynchronously, no done; new start completes normally.
REQ-043 SHALL cover: with POOL_SCHED_TIMEOUT_EN, stub datapath returning only 100 results -> err=1 after 64 DRAIN cycles, next channel still sequenced, done asserted.
REQ-044 SHALL cover: extra mp_out_valid after 196th result of a channel -> no wr_en, out_cnt unchanged.
